// File: rtl/data_mem_ctl_if.sv
// Load/store bus between the CPU datapath (master) and data_mem_ctl (slave).
// DW/AW of an instance must match the parameters of the memory it connects to.
interface data_mem_ctl_if #(
  parameter int DW = 9,
  parameter int AW = 8
);
  logic [AW-1:0] DataAddress;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          DataValid;
  logic          Busy;

  modport master (
    output DataAddress, ReadMem, WriteMem, DataIn,
    input  DataOut, DataValid, Busy
  );

  modport slave (
    input  DataAddress, ReadMem, WriteMem, DataIn,
    output DataOut, DataValid, Busy
  );
endinterface

// File: rtl/data_mem_ctl.sv
// Parametrised single-port data memory with selectable read latency and an
// optional post-reset zero-fill sequencer that stalls the core through Busy.
module data_mem_ctl #(
  parameter int DW             = 9,
  parameter int AW             = 8,
  parameter int READ_LATENCY   = 0,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic           CLK,
  input logic           Reset,
  data_mem_ctl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic [AW-1:0] LAST_ADDR   = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic          WF          = (WRITE_FIRST != 0);

  state_t        state_r;
  logic [AW-1:0] clrPtr_r;
  logic [DW-1:0] mem_r [2**AW];

  logic          ready_s;
  logic          rdEn_s;
  logic          wrEn_s;
  logic [AW-1:0] wrAddr_s;
  logic [DW-1:0] wrData_s;
  logic [DW-1:0] dataOut_s;
  logic          dataValid_s;

  assign ready_s = (state_r == ST_READY);
  assign rdEn_s  = ready_s && bus.ReadMem;
  assign bus.Busy      = (state_r == ST_CLEAR);
  assign bus.DataOut   = dataOut_s;
  assign bus.DataValid = dataValid_s;

  // Single write port shared by the clear sequencer and CPU stores; nothing is written on a reset edge.
  always_comb begin
    wrEn_s   = 1'b0;
    wrAddr_s = bus.DataAddress;
    wrData_s = bus.DataIn;
    if (Reset) begin
      wrEn_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      wrEn_s   = 1'b1;
      wrAddr_s = clrPtr_r;
      wrData_s = {DW{1'b0}};
    end else if (bus.WriteMem) begin
      wrEn_s = 1'b1;
    end else begin
      wrEn_s = 1'b0;
    end
  end

  // Clear/ready state machine; a reset mid-clear restarts the sweep from address 0.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r  <= RESET_STATE;
      clrPtr_r <= {AW{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clrPtr_r <= clrPtr_r + ADDR_ONE;
          if (clrPtr_r == LAST_ADDR) begin
            state_r <= ST_READY;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
        ST_READY: begin
          state_r  <= ST_READY;
          clrPtr_r <= {AW{1'b0}};
        end
        default: begin
          state_r  <= ST_READY;
          clrPtr_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Storage array, deliberately without reset so it maps onto RAM.
  always_ff @(posedge CLK) begin
    if (wrEn_s) begin
      mem_r[wrAddr_s] <= wrData_s;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      // Asynchronous read: a same-cycle store becomes visible only after the edge.
      always_comb begin
        dataOut_s   = {DW{1'b0}};
        dataValid_s = 1'b0;
        if (rdEn_s) begin
          dataOut_s   = mem_r[bus.DataAddress];
          dataValid_s = 1'b1;
        end else begin
          dataOut_s   = {DW{1'b0}};
          dataValid_s = 1'b0;
        end
      end
    end else begin : g_reg_read
      logic [DW-1:0] dataOut_r;
      logic          dataValid_r;

      assign dataOut_s   = dataOut_r;
      assign dataValid_s = dataValid_r;

      // Registered read; DataOut holds its last result when no load is served.
      always_ff @(posedge CLK) begin
        if (Reset) begin
          dataOut_r   <= {DW{1'b0}};
          dataValid_r <= 1'b0;
        end else if (rdEn_s) begin
          dataValid_r <= 1'b1;
          if (WF && bus.WriteMem) begin
            dataOut_r <= bus.DataIn;
          end else begin
            dataOut_r <= mem_r[bus.DataAddress];
          end
        end else begin
          dataValid_r <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_ctl.sv
// Randomised bench for data_mem_ctl: four configurations share one stimulus
// stream and are compared against an array/counter reference model.
module tb_data_mem_ctl;
  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  data_mem_ctl_if #(.DW(DW), .AW(AW)) busA ();
  data_mem_ctl_if #(.DW(DW), .AW(AW)) busB ();
  data_mem_ctl_if #(.DW(DW), .AW(AW)) busC ();
  data_mem_ctl_if #(.DW(DW), .AW(AW)) busD ();

  data_mem_ctl #(.DW(DW), .AW(AW), .READ_LATENCY(0), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
    dutA (.CLK(CLK), .Reset(Reset), .bus(busA));
  data_mem_ctl #(.DW(DW), .AW(AW), .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
    dutB (.CLK(CLK), .Reset(Reset), .bus(busB));
  data_mem_ctl #(.DW(DW), .AW(AW), .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
    dutC (.CLK(CLK), .Reset(Reset), .bus(busC));
  data_mem_ctl #(.DW(DW), .AW(AW), .READ_LATENCY(0), .WRITE_FIRST(1), .CLEAR_ON_RESET(0))
    dutD (.CLK(CLK), .Reset(Reset), .bus(busD));

  // Reference model: memory contents, remaining clear cycles, registered-read results.
  logic [DW-1:0] refMem [DEPTH];
  int            busyLeft;
  logic [DW-1:0] refOutB;
  logic [DW-1:0] refOutC;
  logic          refValid;
  bit            inited;
  int            nChecks;
  int            nErrors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] din);
    busA.ReadMem = rd; busA.WriteMem = wr; busA.DataAddress = addr; busA.DataIn = din;
    busB.ReadMem = rd; busB.WriteMem = wr; busB.DataAddress = addr; busB.DataIn = din;
    busC.ReadMem = rd; busC.WriteMem = wr; busC.DataAddress = addr; busC.DataIn = din;
    busD.ReadMem = rd; busD.WriteMem = wr; busD.DataAddress = addr; busD.DataIn = din;
  endtask

  // One clock cycle: called at a negedge, checks combinational outputs before the
  // posedge, advances the model, and checks registered outputs at the next negedge.
  task automatic cycle(input logic rst, input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    logic busyNow;
    logic served;
    Reset = rst;
    drive(rd, wr, addr, din);
    #1;
    busyNow = (busyLeft > 0);
    served  = rd && !busyNow;
    if (inited) begin
      chk("busyA", busA.Busy, busyNow);
      chk("busyB", busB.Busy, busyNow);
      chk("busyC", busC.Busy, busyNow);
      chk("busyD", busD.Busy, 1'b0);
      chk("validA", busA.DataValid, served);
      chk("outA", busA.DataOut, served ? refMem[addr] : {DW{1'b0}});
      chk("validD", busD.DataValid, rd);
    end
    @(posedge CLK);
    if (rst) begin
      inited   = 1'b1;
      busyLeft = DEPTH;
      refOutB  = '0;
      refOutC  = '0;
      refValid = 1'b0;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    end else if (inited) begin
      if (busyLeft > 0) begin
        busyLeft--;
        refValid = 1'b0;
      end else begin
        if (rd) begin
          refOutB  = wr ? din : refMem[addr];
          refOutC  = refMem[addr];
          refValid = 1'b1;
        end else begin
          refValid = 1'b0;
        end
        if (wr) refMem[addr] = din;
      end
    end
    @(negedge CLK);
    if (inited) begin
      chk("outB", busB.DataOut, refOutB);
      chk("outC", busC.DataOut, refOutC);
      chk("validB", busB.DataValid, refValid);
      chk("validC", busC.DataValid, refValid);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    nChecks  = 0;
    nErrors  = 0;
    inited   = 1'b0;
    busyLeft = 0;
    refValid = 1'b0;
    Reset    = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge CLK);

    // Reset pulse, Busy length and all-zero contents.
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 9'd0);
    cnt = 0;
    while (busA.Busy === 1'b1 && cnt < 40) begin
      cycle(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 9'($urandom));
      cnt++;
    end
    chk("t1_busy_len", cnt, 16);
    for (int a = 0; a < DEPTH; a++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'(a), 9'd0);
      chk("t1_zero", busB.DataOut, 9'd0);
    end

    // Reset again mid-clear; the store attempted during clear must be dropped.
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 9'd0);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0, (k == 3), 4'd3, 9'h155);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 9'd0);
    cnt = 0;
    while (busA.Busy === 1'b1 && cnt < 40) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
      cnt++;
    end
    chk("t2_busy_len", cnt, 16);
    cycle(1'b0, 1'b1, 1'b0, 4'd3, 9'd0);
    chk("t2_dropped", busB.DataOut, 9'd0);

    // Store then load.
    cycle(1'b0, 1'b0, 1'b1, 4'd3, 9'h1A5);
    cycle(1'b0, 1'b1, 1'b0, 4'd3, 9'd0);
    chk("t3_out", busB.DataOut, 9'h1A5);
    cycle(1'b0, 1'b0, 1'b0, 4'd3, 9'd0);

    // Back-to-back registered reads.
    cycle(1'b0, 1'b0, 1'b1, 4'd1, 9'd10);
    cycle(1'b0, 1'b0, 1'b1, 4'd2, 9'd20);
    cycle(1'b0, 1'b0, 1'b1, 4'd3, 9'd30);
    for (int a = 1; a <= 3; a++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'(a), 9'd0);
      chk("t4_out", busB.DataOut, 32'(a * 10));
      chk("t4_valid", busB.DataValid, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
    chk("t4_valid_drop", busB.DataValid, 1'b0);
    chk("t4_hold", busB.DataOut, 9'd30);

    // Same-address read+write with registered read.
    cycle(1'b0, 1'b0, 1'b1, 4'd5, 9'h011);
    cycle(1'b0, 1'b1, 1'b1, 4'd5, 9'h0FF);
    chk("t5_wf1", busB.DataOut, 9'h0FF);
    chk("t5_wf0", busC.DataOut, 9'h011);
    cycle(1'b0, 1'b1, 1'b0, 4'd5, 9'd0);
    chk("t5_next", busC.DataOut, 9'h0FF);

    // Same-address read+write with combinational read (old word, then new).
    cycle(1'b0, 1'b0, 1'b1, 4'd2, 9'd7);
    cycle(1'b0, 1'b1, 1'b1, 4'd2, 9'd9);
    cycle(1'b0, 1'b1, 1'b0, 4'd2, 9'd0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 149) == 0), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)), 9'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
